// File: rtl/command_decoder.sv
// Frames the SPI byte stream into op-code / operand strobes for the graphics block.
// The first byte of each select window is the op code; later bytes are counted operands.
module command_decoder #(
  parameter int MIN_GAP_CYCLES    = 1,
  parameter int MAX_OPERAND_COUNT = 65535
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        spi_select_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_ready_in,
  output logic [7:0]  op_code_out,
  output logic        op_code_valid_out,
  output logic [7:0]  operand_out,
  output logic        operand_valid_out,
  output logic [31:0] operand_count_out,
  output logic        overflow_out
);

  localparam logic [31:0] GAP_LAST  = 32'(MIN_GAP_CYCLES - 1);
  localparam logic [31:0] MAX_COUNT = 32'(MAX_OPERAND_COUNT);

  typedef enum logic [2:0] {
    IDLE_WAIT_LOW,
    IDLE,
    WAIT_OPCODE,
    OPERANDS,
    GAP
  } state_t;

  state_t      state_reg, state_next;
  logic        byte_ready_prev_reg;
  logic [31:0] gap_count_reg, gap_count_next;
  logic [7:0]  op_code_reg, op_code_next;
  logic        op_code_valid_reg, op_code_valid_next;
  logic [7:0]  operand_reg, operand_next;
  logic        operand_valid_reg, operand_valid_next;
  logic [31:0] operand_count_reg, operand_count_next;
  logic        overflow_reg, overflow_next;

  logic byte_event;
  logic gap_done;

  assign byte_event = byte_ready_in & ~byte_ready_prev_reg & spi_select_in;
  assign gap_done   = (gap_count_reg == GAP_LAST);

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_reg           <= IDLE_WAIT_LOW;
      byte_ready_prev_reg <= 1'b0;
      gap_count_reg       <= '0;
      op_code_reg         <= '0;
      op_code_valid_reg   <= 1'b0;
      operand_reg         <= '0;
      operand_valid_reg   <= 1'b0;
      operand_count_reg   <= '0;
      overflow_reg        <= 1'b0;
    end else begin
      state_reg           <= state_next;
      byte_ready_prev_reg <= byte_ready_in;
      gap_count_reg       <= gap_count_next;
      op_code_reg         <= op_code_next;
      op_code_valid_reg   <= op_code_valid_next;
      operand_reg         <= operand_next;
      operand_valid_reg   <= operand_valid_next;
      operand_count_reg   <= operand_count_next;
      overflow_reg        <= overflow_next;
    end
  end

  // Select falling always wins over a simultaneous byte event.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE_WAIT_LOW: if (!spi_select_in) state_next = IDLE;
      IDLE:          if (spi_select_in) state_next = WAIT_OPCODE;
      WAIT_OPCODE: begin
        if (!spi_select_in)  state_next = GAP;
        else if (byte_event) state_next = OPERANDS;
      end
      OPERANDS:      if (!spi_select_in) state_next = GAP;
      GAP:           if (gap_done) state_next = spi_select_in ? WAIT_OPCODE : IDLE;
      default:       state_next = IDLE_WAIT_LOW;
    endcase
  end

  always_comb begin
    gap_count_next     = gap_count_reg;
    op_code_next       = op_code_reg;
    op_code_valid_next = op_code_valid_reg;
    operand_next       = operand_reg;
    operand_valid_next = 1'b0;
    operand_count_next = operand_count_reg;
    overflow_next      = overflow_reg;
    case (state_reg)
      WAIT_OPCODE, OPERANDS: begin
        if (!spi_select_in) begin
          op_code_valid_next = 1'b0;
          operand_count_next = '0;
          gap_count_next     = '0;
        end else if (byte_event) begin
          if (state_reg == WAIT_OPCODE) begin
            op_code_next       = byte_in;
            op_code_valid_next = 1'b1;
            operand_count_next = '0;
            overflow_next      = 1'b0;
          end else if (operand_count_reg < MAX_COUNT) begin
            operand_next       = byte_in;
            operand_count_next = operand_count_reg + 32'd1;
            operand_valid_next = 1'b1;
          end else begin
            overflow_next = 1'b1;
          end
        end
      end
      GAP:     gap_count_next = gap_count_reg + 32'd1;
      default: ;
    endcase
  end

  assign op_code_out       = op_code_reg;
  assign op_code_valid_out = op_code_valid_reg;
  assign operand_out       = operand_reg;
  assign operand_valid_out = operand_valid_reg;
  assign operand_count_out = operand_count_reg;
  assign overflow_out      = overflow_reg;

endmodule

// File: tb/tb_command_decoder.sv
// Directed bench for command_decoder: a main instance (gap 3, full count range) and a
// second instance with MAX_OPERAND_COUNT=3 sharing the same stimulus for overflow cases.
module tb_command_decoder;

  logic        clock_in = 1'b0;
  logic        reset_n_in;
  logic        spi_select_in;
  logic [7:0]  byte_in;
  logic        byte_ready_in;

  logic [7:0]  op_code_out, operand_out;
  logic        op_code_valid_out, operand_valid_out, overflow_out;
  logic [31:0] operand_count_out;

  logic [7:0]  op_code_ovf, operand_ovf;
  logic        op_code_valid_ovf, operand_valid_ovf, overflow_ovf;
  logic [31:0] operand_count_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clock_in = ~clock_in;

  command_decoder #(.MIN_GAP_CYCLES(3), .MAX_OPERAND_COUNT(65535)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in), .spi_select_in(spi_select_in),
    .byte_in(byte_in), .byte_ready_in(byte_ready_in),
    .op_code_out(op_code_out), .op_code_valid_out(op_code_valid_out),
    .operand_out(operand_out), .operand_valid_out(operand_valid_out),
    .operand_count_out(operand_count_out), .overflow_out(overflow_out)
  );

  command_decoder #(.MIN_GAP_CYCLES(3), .MAX_OPERAND_COUNT(3)) dut_ovf (
    .clock_in(clock_in), .reset_n_in(reset_n_in), .spi_select_in(spi_select_in),
    .byte_in(byte_in), .byte_ready_in(byte_ready_in),
    .op_code_out(op_code_ovf), .op_code_valid_out(op_code_valid_ovf),
    .operand_out(operand_ovf), .operand_valid_out(operand_valid_ovf),
    .operand_count_out(operand_count_ovf), .overflow_out(overflow_ovf)
  );

  typedef struct {
    logic        sel;
    logic        rdy;
    logic [7:0]  b;
    logic [7:0]  op;
    logic        opv;
    logic [7:0]  opd;
    logic        opdv;
    logic [31:0] cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[24];

  // Drive inputs just after an edge, then return 1 time unit after the next edge.
  task automatic step(input logic sel, input logic rdy, input logic [7:0] b);
    spi_select_in = sel;
    byte_ready_in = rdy;
    byte_in       = b;
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int pulses;
    logic [7:0] b;

    vecs = '{
      '{1'b0,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,32'd0,1'b0},
      '{1'b1,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,32'd0,1'b0},
      '{1'b1,1'b1,8'h11, 8'h11,1'b1,8'h00,1'b0,32'd0,1'b0},
      '{1'b1,1'b0,8'h11, 8'h11,1'b1,8'h00,1'b0,32'd0,1'b0},
      '{1'b1,1'b1,8'h03, 8'h11,1'b1,8'h03,1'b1,32'd1,1'b0},
      '{1'b1,1'b0,8'h03, 8'h11,1'b1,8'h03,1'b0,32'd1,1'b0},
      '{1'b1,1'b1,8'h50, 8'h11,1'b1,8'h50,1'b1,32'd2,1'b0},
      '{1'b1,1'b1,8'h50, 8'h11,1'b1,8'h50,1'b0,32'd2,1'b0},
      '{1'b1,1'b0,8'h50, 8'h11,1'b1,8'h50,1'b0,32'd2,1'b0},
      '{1'b1,1'b1,8'h60, 8'h11,1'b1,8'h60,1'b1,32'd3,1'b0},
      '{1'b1,1'b0,8'h60, 8'h11,1'b1,8'h60,1'b0,32'd3,1'b0},
      '{1'b1,1'b1,8'h80, 8'h11,1'b1,8'h80,1'b1,32'd4,1'b0},
      '{1'b1,1'b0,8'h80, 8'h11,1'b1,8'h80,1'b0,32'd4,1'b0},
      '{1'b0,1'b0,8'h80, 8'h11,1'b0,8'h80,1'b0,32'd0,1'b0},
      '{1'b0,1'b0,8'h00, 8'h11,1'b0,8'h80,1'b0,32'd0,1'b0},
      '{1'b0,1'b0,8'h00, 8'h11,1'b0,8'h80,1'b0,32'd0,1'b0},
      '{1'b0,1'b0,8'h00, 8'h11,1'b0,8'h80,1'b0,32'd0,1'b0},
      '{1'b1,1'b0,8'h00, 8'h11,1'b0,8'h80,1'b0,32'd0,1'b0},
      '{1'b1,1'b1,8'h20, 8'h20,1'b1,8'h80,1'b0,32'd0,1'b0},
      '{1'b1,1'b0,8'h20, 8'h20,1'b1,8'h80,1'b0,32'd0,1'b0},
      '{1'b1,1'b1,8'h21, 8'h20,1'b1,8'h21,1'b1,32'd1,1'b0},
      '{1'b1,1'b0,8'h21, 8'h20,1'b1,8'h21,1'b0,32'd1,1'b0},
      '{1'b0,1'b1,8'h22, 8'h20,1'b0,8'h21,1'b0,32'd0,1'b0},
      '{1'b0,1'b0,8'h00, 8'h20,1'b0,8'h21,1'b0,32'd0,1'b0}
    };

    // Reset state
    reset_n_in = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("rst_op", {24'd0, op_code_out}, 32'd0);
    chk("rst_opv", {31'd0, op_code_valid_out}, 32'd0);
    chk("rst_opd", {24'd0, operand_out}, 32'd0);
    chk("rst_opdv", {31'd0, operand_valid_out}, 32'd0);
    chk("rst_cnt", operand_count_out, 32'd0);
    chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
    reset_n_in = 1'b1;

    // Basic framing plus select-fall/byte-rise collision
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].sel, vecs[i].rdy, vecs[i].b);
      checks++;
      if (op_code_out !== vecs[i].op || op_code_valid_out !== vecs[i].opv ||
          operand_out !== vecs[i].opd || operand_valid_out !== vecs[i].opdv ||
          operand_count_out !== vecs[i].cnt || overflow_out !== vecs[i].ovf) begin
        errors++;
        $display("FAIL vec%0d: got op=%h v=%b opd=%h pv=%b cnt=%0d ovf=%b expected op=%h v=%b opd=%h pv=%b cnt=%0d ovf=%b",
                 i, op_code_out, op_code_valid_out, operand_out, operand_valid_out,
                 operand_count_out, overflow_out, vecs[i].op, vecs[i].opv, vecs[i].opd,
                 vecs[i].opdv, vecs[i].cnt, vecs[i].ovf);
      end
    end
    idle(4);

    // Single-byte command, reselect immediately, byte inside gap ignored
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h10);
    chk("gap_op10", {24'd0, op_code_out}, 32'h10);
    chk("gap_op10_v", {31'd0, op_code_valid_out}, 32'd1);
    step(1'b1, 1'b0, 8'h00);
    chk("gap_no_pulse", {31'd0, operand_valid_out}, 32'd0);
    step(1'b0, 1'b0, 8'h00);
    chk("gap_v0_a", {31'd0, op_code_valid_out}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("gap_v0_b", {31'd0, op_code_valid_out}, 32'd0);
    step(1'b1, 1'b1, 8'h14);
    chk("gap_ign_op", {24'd0, op_code_out}, 32'h10);
    chk("gap_v0_c", {31'd0, op_code_valid_out}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("gap_v0_d", {31'd0, op_code_valid_out}, 32'd0);
    step(1'b1, 1'b1, 8'h14);
    chk("gap_op14", {24'd0, op_code_out}, 32'h14);
    chk("gap_op14_v", {31'd0, op_code_valid_out}, 32'd1);
    idle(6);

    // Held byte_ready: op 0x12 plus 10 operands, 5 cycles high each
    pulses = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k <= 10; k++) begin
      b = (k == 0) ? 8'h12 : 8'h30 + 8'(k);
      for (int c = 0; c < 5; c++) begin
        step(1'b1, 1'b1, b);
        chk($sformatf("held_pv_k%0d_c%0d", k, c), {31'd0, operand_valid_out},
            {31'd0, (k > 0 && c == 0)});
        if (operand_valid_out) begin
          pulses++;
          chk($sformatf("held_cnt_k%0d", k), operand_count_out, 32'(k));
          chk($sformatf("held_opd_k%0d", k), {24'd0, operand_out}, {24'd0, b});
        end
      end
      step(1'b1, 1'b0, 8'h00);
    end
    chk("held_op12", {24'd0, op_code_out}, 32'h12);
    chk("held_pulses", 32'(pulses), 32'd10);
    step(1'b0, 1'b0, 8'h00);
    chk("held_cnt0", operand_count_out, 32'd0);
    idle(6);

    // Overflow on the MAX_OPERAND_COUNT=3 instance
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h13);
    chk("ovf_op13", {24'd0, op_code_ovf}, 32'h13);
    chk("ovf_clr_a", {31'd0, overflow_ovf}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 8'h40 + 8'(k));
      chk($sformatf("ovf_pv_%0d", k), {31'd0, operand_valid_ovf}, {31'd0, (k < 3)});
      chk($sformatf("ovf_cnt_%0d", k), operand_count_ovf, (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("ovf_flag_%0d", k), {31'd0, overflow_ovf}, {31'd0, (k >= 3)});
      chk($sformatf("ovf_opd_%0d", k), {24'd0, operand_ovf}, (k < 3) ? 32'h40 + 32'(k) : 32'h42);
      step(1'b1, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_sticky", {31'd0, overflow_ovf}, 32'd1);
    idle(5);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h15);
    chk("ovf_op15", {24'd0, op_code_ovf}, 32'h15);
    chk("ovf_clr_b", {31'd0, overflow_ovf}, 32'd0);
    idle(6);

    // Reset mid-transaction with select held high
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h16);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hA1);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hA2);
    chk("mid_cnt2", operand_count_out, 32'd2);
    step(1'b1, 1'b0, 8'h00);
    reset_n_in = 1'b0;
    step(1'b1, 1'b0, 8'h00);
    chk("mid_rst_all", {op_code_out, operand_out, 7'd0, op_code_valid_out,
                        7'd0, operand_valid_out}, 32'd0);
    chk("mid_rst_cnt", operand_count_out, 32'd0);
    reset_n_in = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h33);
    chk("mid_ign_v", {31'd0, op_code_valid_out}, 32'd0);
    chk("mid_ign_op", {24'd0, op_code_out}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h44);
    chk("mid_op44", {24'd0, op_code_out}, 32'h44);
    chk("mid_op44_v", {31'd0, op_code_valid_out}, 32'd1);
    chk("mid_cnt0", operand_count_out, 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
